// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam int unsigned SIZE_W = 3;

endpackage

// File: rtl/mux_2to1_3bit.sv
// 3-bit two-way multiplexer for the funct3 access-size field.
module mux_2to1_3bit (
  input  logic [2:0] d0,
  input  logic [2:0] d1,
  input  logic       sel,
  output logic [2:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (0)
// and load/store (1); holds the command select for a whole transaction.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [SIZE_W-1:0] i_size0,
  input  logic [SIZE_W-1:0] i_size1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic [SIZE_W-1:0] o_mem_size,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_sel
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt1_q, mem_req_q;
  logic       any_req;
  logic       ack_c;

  // On a tie the requester that did not own the port last time wins.
  function automatic logic pick_owner(input logic req0, input logic req1,
                                      input logic prio_last);
    if (req0 && req1) begin
      return ~prio_last;
    end else if (req1) begin
      return OWNER_LSU;
    end else begin
      return OWNER_IF;
    end
  endfunction

  assign any_req = i_req0 | i_req1;
  assign ack_c   = (state_q == BUSY) & i_mem_ack;

  // Next-state: an ack re-arbitrates in the same cycle so handoff has no bubble.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = pick_owner(i_req0, i_req1, last_q);
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          last_d = owner_q;
          if (any_req) begin
            owner_d = pick_owner(i_req0, i_req1, owner_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_IF;
      last_q    <= OWNER_LSU;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt0_q    <= (state_d == BUSY) && (owner_d == OWNER_IF);
      gnt1_q    <= (state_d == BUSY) && (owner_d == OWNER_LSU);
      mem_req_q <= (state_d == BUSY);
    end
  end

  assign o_gnt0    = gnt0_q;
  assign o_gnt1    = gnt1_q;
  assign o_mem_req = mem_req_q;
  assign o_sel     = owner_q;

  // Ack and read data go straight back to the owner in the ack cycle.
  assign o_ack0  = ack_c & (owner_q == OWNER_IF);
  assign o_ack1  = ack_c & (owner_q == OWNER_LSU);
  assign o_rdata = ack_c ? i_mem_rdata : '0;

  assign o_mem_addr  = (owner_q == OWNER_LSU) ? i_addr1  : i_addr0;
  assign o_mem_wdata = (owner_q == OWNER_LSU) ? i_wdata1 : i_wdata0;
  assign o_mem_we    = (owner_q == OWNER_LSU) ? i_we1    : i_we0;

  mux_2to1_3bit u_size_mux (
    .d0  (i_size0),
    .d1  (i_size1),
    .sel (owner_q),
    .y   (o_mem_size)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random run.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [2:0]  size0 = '0, size1 = '0;
  logic        gnt0, gnt1, ack0, ack1, mem_req, mem_we, sel;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1),
    .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_we0(we0), .i_we1(we1),
    .i_size0(size0), .i_size1(size1),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_ack0(ack0), .o_ack1(ack1),
    .o_rdata(rdata),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_size(mem_size),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_sel(sel)
  );

  task automatic clear_inputs();
    req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    we0 = 0; we1 = 0; size0 = '0; size1 = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; addr0 = 32'h55; wdata0 = 32'hA5A5_0001; we0 = 1; size0 = 3'b101;
    addr1 = 32'h77; wdata1 = 32'h0; we1 = 0; size1 = 3'b010;
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    rst_n = 0; #2;
    checks++; if ({gnt0, gnt1, ack0, ack1, mem_req, sel} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {gnt0, gnt1, ack0, ack1, mem_req, sel}); end
    checks++; if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({mem_addr, mem_wdata, mem_we, mem_size} !== {32'h55, 32'hA5A5_0001, 1'b1, 3'b101}) begin
      errors++; $display("FAIL reset_cmd got=%h/%h/%b/%b exp=req0 inputs", mem_addr, mem_wdata, mem_we, mem_size); end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_single();
    int acks = 0;
    req0 = 1; addr0 = 32'h100; size0 = 3'b010; we0 = 0;
    @(negedge clk);
    checks++; if ({gnt0, mem_req} !== 2'b00) begin
      errors++; $display("FAIL single_latency got=%b exp=00", {gnt0, mem_req}); end
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin mem_ack = 1; mem_rdata = 32'hCAFE_0001; req0 = 0; end
      @(negedge clk);
      checks++; if ({gnt0, gnt1, mem_req} !== 3'b101) begin
        errors++; $display("FAIL single_gnt c=%0d got=%b exp=101", c, {gnt0, gnt1, mem_req}); end
      checks++; if ({mem_addr, mem_size} !== {32'h100, 3'b010}) begin
        errors++; $display("FAIL single_cmd c=%0d got=%h/%b exp=100/010", c, mem_addr, mem_size); end
      checks++; if (ack0 !== (c == 2)) begin
        errors++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, ack0, (c == 2)); end
      if (ack0 === 1'b1) acks++;
      @(posedge clk); #1;
    end
    mem_ack = 0;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, mem_req, ack0} !== 4'b0) begin
      errors++; $display("FAIL single_idle got=%b exp=0000", {gnt0, gnt1, mem_req, ack0}); end
    checks++; if (acks !== 1) begin
      errors++; $display("FAIL single_ack_count got=%0d exp=1", acks); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    addr0 = 32'hA0; addr1 = 32'hB0; req0 = 1; req1 = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_first_idle got=%b exp=0", mem_req); end
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      logic e;
      e = 1'(t % 2);
      for (int b = 0; b < 2; b++) begin
        if (b == 1) begin
          mem_ack = 1;
          if (t == 3) begin req0 = 0; req1 = 0; end
        end
        @(negedge clk);
        checks++; if ({gnt0, gnt1, mem_req, sel} !== {~e, e, 1'b1, e}) begin
          errors++; $display("FAIL b2b_gnt t=%0d b=%0d got=%b exp=%b", t, b, {gnt0, gnt1, mem_req, sel}, {~e, e, 1'b1, e}); end
        checks++; if (mem_addr !== (e ? 32'hB0 : 32'hA0)) begin
          errors++; $display("FAIL b2b_addr t=%0d got=%h exp=%h", t, mem_addr, (e ? 32'hB0 : 32'hA0)); end
        checks++; if ({ack0, ack1} !== ((b == 1) ? {~e, e} : 2'b00)) begin
          errors++; $display("FAIL b2b_ack t=%0d b=%0d got=%b", t, b, {ack0, ack1}); end
        @(posedge clk); #1;
        mem_ack = 0;
      end
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_end_idle got=%b exp=0", mem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_preempt();
    apply_reset();
    req1 = 1; we1 = 1; wdata1 = 32'hDEAD_BEEF; size1 = 3'b000; addr1 = 32'h400;
    addr0 = 32'h200; wdata0 = 32'h1111_1111; we0 = 0; size0 = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, sel} !== 3'b011) begin
      errors++; $display("FAIL store_gnt1 got=%b exp=011", {gnt0, gnt1, sel}); end
    checks++; if ({mem_wdata, mem_we, mem_size} !== {32'hDEAD_BEEF, 1'b1, 3'b000}) begin
      errors++; $display("FAIL store_cmd got=%h/%b/%b exp=deadbeef/1/000", mem_wdata, mem_we, mem_size); end
    @(posedge clk); #1;
    req0 = 1;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, mem_wdata} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_hold got=%b%b/%h exp=01/deadbeef", gnt0, gnt1, mem_wdata); end
    @(posedge clk); #1;
    mem_ack = 1; req1 = 0;
    @(negedge clk);
    checks++; if ({ack0, ack1, mem_wdata} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_ack got=%b%b/%h exp=01/deadbeef", ack0, ack1, mem_wdata); end
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, sel, mem_req} !== 4'b1001) begin
      errors++; $display("FAIL store_handoff got=%b exp=1001", {gnt0, gnt1, sel, mem_req}); end
    checks++; if ({mem_addr, mem_wdata, mem_we, mem_size} !== {32'h200, 32'h1111_1111, 1'b0, 3'b010}) begin
      errors++; $display("FAIL store_next_cmd got=%h/%h/%b/%b", mem_addr, mem_wdata, mem_we, mem_size); end
    @(posedge clk); #1;
    mem_ack = 1; req0 = 0;
    @(negedge clk);
    checks++; if ({ack0, ack1} !== 2'b10) begin
      errors++; $display("FAIL store_ack0 got=%b exp=10", {ack0, ack1}); end
    @(posedge clk); #1;
    mem_ack = 0;
  endtask

  task automatic test_idle_ack();
    apply_reset();
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({ack0, ack1, mem_req, rdata} !== {3'b000, 32'h0}) begin
        errors++; $display("FAIL idle_ack c=%0d got=%b%b%b/%h exp=000/0", c, ack0, ack1, mem_req, rdata); end
      @(posedge clk); #1;
    end
    mem_ack = 0;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, mem_req} !== 3'b000) begin
      errors++; $display("FAIL idle_after got=%b exp=000", {gnt0, gnt1, mem_req}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req1 = 1; addr1 = 32'h300; we1 = 1; wdata1 = 32'h0BAD_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, mem_req, sel} !== 4'b0111) begin
      errors++; $display("FAIL rstmid_busy got=%b exp=0111", {gnt0, gnt1, mem_req, sel}); end
    #1 mem_ack = 1; rst_n = 0;
    #1;
    checks++; if ({gnt0, gnt1, mem_req, sel, ack0, ack1} !== 6'b0) begin
      errors++; $display("FAIL rstmid_drop got=%b exp=000000", {gnt0, gnt1, mem_req, sel, ack0, ack1}); end
    @(posedge clk); #1;
    rst_n = 1; mem_ack = 0; req0 = 1; req1 = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got=%b exp=0", mem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({gnt0, gnt1, sel} !== 3'b100) begin
      errors++; $display("FAIL rstmid_tie got=%b exp=100", {gnt0, gnt1, sel}); end
    mem_ack = 1; req0 = 0; req1 = 0;
    @(posedge clk); #1;
    mem_ack = 0;
  endtask

  task automatic test_drop_request();
    apply_reset();
    req1 = 1; addr1 = 32'h600;
    @(posedge clk); #1;
    req1 = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin mem_ack = 1; mem_rdata = 32'h1234_5678; end
      @(negedge clk);
      checks++; if ({gnt1, ack1} !== {1'b1, (c == 2)}) begin
        errors++; $display("FAIL drop_c%0d got=%b%b", c, gnt1, ack1); end
      if (c == 2) begin
        checks++; if (rdata !== 32'h1234_5678) begin
          errors++; $display("FAIL drop_rdata got=%h exp=12345678", rdata); end
      end
      @(posedge clk); #1;
    end
    mem_ack = 0;
    @(negedge clk);
    checks++; if ({gnt1, mem_req, ack1, rdata} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL drop_idle got=%b%b%b/%h", gnt1, mem_req, ack1, rdata); end
    @(posedge clk); #1;
  endtask

  // Reference: owner is -1 when the port is free; an ack frees the port and
  // the freed port is re-offered in the same cycle with the old owner as 'last'.
  task automatic test_random();
    int   m_owner;
    logic m_last, m_sel, e_ack;
    apply_reset();
    m_owner = -1; m_last = 1'b1; m_sel = 1'b0;
    for (int n = 0; n < 400; n++) begin
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (m_owner == 0) begin
        if (mem_ack) req0 = 1'($urandom_range(0, 1));
      end else begin
        req0 = ($urandom_range(0, 3) != 0); addr0 = $urandom; wdata0 = $urandom;
        we0 = 1'($urandom_range(0, 1)); size0 = 3'($urandom_range(0, 7));
      end
      if (m_owner == 1) begin
        if (mem_ack) req1 = 1'($urandom_range(0, 1));
      end else begin
        req1 = ($urandom_range(0, 3) != 0); addr1 = $urandom; wdata1 = $urandom;
        we1 = 1'($urandom_range(0, 1)); size1 = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      e_ack = (m_owner >= 0) && mem_ack;
      checks++; if ({gnt0, gnt1, ack0, ack1, mem_req, sel} !==
                    {m_owner == 0, m_owner == 1, e_ack && m_owner == 0, e_ack && m_owner == 1, m_owner >= 0, m_sel}) begin
        errors++; $display("FAIL rand_ctrl n=%0d got=%b owner=%0d sel=%b", n, {gnt0, gnt1, ack0, ack1, mem_req, sel}, m_owner, m_sel); end
      checks++; if (rdata !== (e_ack ? mem_rdata : 32'h0)) begin
        errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, rdata, (e_ack ? mem_rdata : 32'h0)); end
      checks++; if ({mem_addr, mem_wdata, mem_we, mem_size} !==
                    (m_sel ? {addr1, wdata1, we1, size1} : {addr0, wdata0, we0, size0})) begin
        errors++; $display("FAIL rand_cmd n=%0d got=%h/%h/%b/%b sel=%b", n, mem_addr, mem_wdata, mem_we, mem_size, m_sel); end
      @(posedge clk);
      if (m_owner >= 0 && mem_ack) begin
        m_last = 1'(m_owner);
        m_owner = -1;
      end
      if (m_owner < 0 && (req0 || req1)) begin
        if (req0 && req1) m_owner = m_last ? 0 : 1;
        else m_owner = req1 ? 1 : 0;
        m_sel = 1'(m_owner);
      end
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_store_preempt();
    test_idle_ack();
    test_reset_mid();
    test_drop_request();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that shares one memory port between the instruction-fetch path (requester 0) and the load/store path (requester 1). It owns the select line of the address, write-data, write-enable and 3-bit access-size (funct3) multiplexers in front of the memory. It holds that select for the full length of a multi-cycle transaction, and it routes the memory acknowledge and read data back to the owner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req0 / i_req1  in  1  transaction request, requester 0 / 1
- i_addr0 / i_addr1  in  ADDR_W  address
- i_wdata0 / i_wdata1  in  DATA_W  write data
- i_we0 / i_we1  in  1  write enable
- i_size0 / i_size1  in  3  access size (funct3 encoding)
- o_gnt0 / o_gnt1  out  1  requester owns the port (level, whole transaction)
- o_ack0 / o_ack1  out  1  transaction done (one-cycle pulse)
- o_rdata  out  DATA_W  read data, valid with o_ackN
- o_mem_req  out  1  memory request
- o_mem_addr, o_mem_wdata, o_mem_we, o_mem_size  out  ADDR_W / DATA_W / 1 / 3  muxed command
- i_mem_ack  in  1  memory done
- i_mem_rdata  in  DATA_W  memory read data
- o_sel  out  1  current owner (0 or 1), exported for debug

## Operation
- States: IDLE and BUSY. A 1-bit owner register drives o_sel. A 1-bit last register holds the previous owner and sets round-robin priority.
- IDLE: when any i_reqN=1, move to BUSY on the next edge. Winner selection:
  - single request: that requester wins;
  - both requesting: the requester other than last wins.
  - Latch the winner into owner.
- BUSY:
  - o_mem_req=1 and o_gnt[owner]=1.
  - The command outputs are the owner's inputs, passed combinationally through the muxes (o_sel=owner).
  - The owner holds its command stable until its ack.
- i_mem_ack=1 in BUSY:
  - o_ack[owner]=1 in the same cycle; o_rdata=i_mem_rdata.
  - last<=owner.
  - Arbitration is repeated in the same cycle using the updated priority, with the current owner excluded from first choice. If any request is pending, stay in BUSY with the new owner (back-to-back, no idle bubble); otherwise go to IDLE.
- A request dropped during BUSY is ignored. The transaction completes and the ack is still delivered.
- i_mem_ack in IDLE is ignored: no ack and no state change.
- The non-owner's o_gnt and o_ack stay 0 at all times.
- o_rdata=0 whenever no ack is asserted.

## Timing
- Reset (async assert, sync release): state=IDLE, owner=0, last=1 (requester 0 wins the first tie). Reset values of all outputs:
  - o_gnt0/1=0, o_ack0/1=0, o_mem_req=0, o_rdata=0, o_sel=0;
  - command outputs follow requester 0's inputs.
- Grant latency: request seen in IDLE at edge k → o_gnt and o_mem_req high from cycle k+1.
- A transaction lasts from grant until the cycle where i_mem_ack=1, inclusive. Minimum length is 1 cycle (ack in the first BUSY cycle).
- Back-to-back handoff: ack in cycle n, other requester pending → its grant starts in cycle n+1.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and outputs take their reset values immediately.

## Structure
- Package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_e;
  - localparams OWNER_IF=1'b0 and OWNER_LSU=1'b1.
- The size field goes through one instance of the existing mux_2to1_3bit, with o_sel as its select. Address, write data and write enable use plain 2:1 selects.
- The priority/next-owner logic is one combinational function inside the module. No further sub-module.

## Test plan
- Reset then i_req0=1, addr0=0x100, size0=3'b010, ack after 3 BUSY cycles → o_gnt0 high for 3 cycles, o_mem_addr=0x100, o_mem_size=010, o_ack0 pulses once, return to IDLE.
- Both requests from the same edge, ack every 2nd BUSY cycle, 4 transactions → grant order 0,1,0,1 with no IDLE cycles between them.
- Owner 1 store (we1=1, wdata1=0xDEADBEEF, size1=3'b000) while i_req0 rises mid-transaction → o_mem_wdata=0xDEADBEEF until ack, then o_gnt0 in the next cycle.
- i_mem_ack pulsed while IDLE → no o_ack, o_mem_req stays 0.
- i_rst_n low during BUSY with owner 1 → o_gnt1 and o_mem_req fall immediately, no ack; after release a tie is granted to requester 0.
- i_req1 dropped after grant, ack 2 cycles later with rdata=0x12345678 → o_ack1 pulses with o_rdata=0x12345678, then IDLE.
